// File: rtl/rsa_modexp_seq.sv
// Square-and-multiply sequencer for modular exponentiation: walks the exponent MSB-first
// and issues one LOAD/SQUARE/MULT op at a time. Optional watchdog: RSA_SEQ_WATCHDOG_EN.
module rsa_modexp_seq #(
   parameter int EXP_W = 1024,
   parameter int CNT_W = 16,
   parameter int TMO_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [EXP_W-1:0] exp,
   output logic             busy,
   output logic             done,
   output logic             op_start,
   output logic [1:0]       op_code,
   input  logic             op_done,
   output logic [CNT_W-1:0] op_count,
   output logic             error
);
   localparam int BL_W = $clog2(EXP_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_LOAD_ONE, OP_LOAD_BASE, OP_SQUARE, OP_MULT} op_t;

   state_t           state, state_nx;
   op_t              next_op, next_op_nx;
   logic [EXP_W-1:0] e_reg, e_nx;
   logic [BL_W-1:0]  bits_left, bits_nx;
   logic             bit_reg, bit_nx;
   logic             last, last_nx;
   logic [CNT_W-1:0] cnt_nx;
`ifdef RSA_SEQ_WATCHDOG_EN
   logic [TMO_W-1:0] tmo, tmo_nx;
   logic             err_q, err_nx;
`endif

   assign busy     = (state == S_SCAN) || (state == S_ISSUE) || (state == S_WAIT);
   assign done     = (state == S_DONE);
   assign op_start = (state == S_ISSUE);
   assign op_code  = next_op;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_nx   = state;
      next_op_nx = next_op;
      e_nx       = e_reg;
      bits_nx    = bits_left;
      bit_nx     = bit_reg;
      last_nx    = last;
      cnt_nx     = op_count;
`ifdef RSA_SEQ_WATCHDOG_EN
      tmo_nx     = tmo;
      err_nx     = err_q;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               e_nx     = exp;
               bits_nx  = BL_W'(EXP_W);
               cnt_nx   = '0;
               last_nx  = 1'b0;
               state_nx = S_SCAN;
`ifdef RSA_SEQ_WATCHDOG_EN
               err_nx   = 1'b0;
`endif
            end
         end
         S_SCAN: begin
            bit_nx  = e_reg[EXP_W-1];
            e_nx    = e_reg << 1;
            bits_nx = bits_left - BL_W'(1);
            if (e_reg[EXP_W-1]) begin
               next_op_nx = OP_LOAD_BASE;
               state_nx   = S_ISSUE;
            end else if (bits_left == BL_W'(1)) begin
               // All-zero exponent: the result is simply 1.
               next_op_nx = OP_LOAD_ONE;
               last_nx    = 1'b1;
               state_nx   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (op_count != '1) cnt_nx = op_count + CNT_W'(1);
            state_nx = S_WAIT;
`ifdef RSA_SEQ_WATCHDOG_EN
            tmo_nx   = '0;
`endif
         end
         S_WAIT: begin
            if (op_done) begin
               if (last) begin
                  state_nx = S_DONE;
               end else if (next_op == OP_SQUARE && bit_reg) begin
                  next_op_nx = OP_MULT;
                  state_nx   = S_ISSUE;
               end else if (bits_left == '0) begin
                  state_nx = S_DONE;
               end else begin
                  bit_nx     = e_reg[EXP_W-1];
                  e_nx       = e_reg << 1;
                  bits_nx    = bits_left - BL_W'(1);
                  next_op_nx = OP_SQUARE;
                  state_nx   = S_ISSUE;
               end
`ifdef RSA_SEQ_WATCHDOG_EN
            end else if (tmo == '1) begin
               err_nx   = 1'b1;
               state_nx = S_DONE;
            end else begin
               tmo_nx = tmo + TMO_W'(1);
`endif
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         next_op   <= OP_LOAD_ONE;
         e_reg     <= '0;
         bits_left <= '0;
         bit_reg   <= 1'b0;
         last      <= 1'b0;
         op_count  <= '0;
`ifdef RSA_SEQ_WATCHDOG_EN
         tmo       <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         next_op   <= next_op_nx;
         e_reg     <= e_nx;
         bits_left <= bits_nx;
         bit_reg   <= bit_nx;
         last      <= last_nx;
         op_count  <= cnt_nx;
`ifdef RSA_SEQ_WATCHDOG_EN
         tmo       <= tmo_nx;
         err_q     <= err_nx;
`endif
      end
   end

`ifdef RSA_SEQ_WATCHDOG_EN
   assign error = err_q;
`else
   assign error = |{TMO_W{1'b0}};
`endif

endmodule
